// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  // FSM state codes
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  // Which requester currently owns the SRAM port
  typedef enum logic {
    OWNER_IF   = 1'b0,
    OWNER_DATA = 1'b1
  } arb_owner_e;

  localparam int  SRAM_WAIT_DEFAULT = 2;
  localparam logic CHIP_ENABLE      = 1'b1;
  localparam logic WRITE_ENABLE     = 1'b1;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM port between fetch and data requesters, data has priority.
// Each access: IDLE (grant) -> ACCESS (WAIT_CYCLES strobe cycles) -> DONE (ack).
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = SRAM_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_ack_o,
  output logic              stallreq_if_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ack_o,
  output logic              stallreq_mem_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o,
  output logic [31:0]       sram_wdata_o,
  output logic              sram_wdata_oe_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  // we_n is low in the first ACCESS cycle only when another cycle follows
  localparam logic       WE_FIRST = (CNT_INIT != 4'd0);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              wdata_oe_q, wdata_oe_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;

  // Next-state, latch and registered-strobe computation
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    wdata_oe_d = 1'b0;
    if_ack_d   = 1'b0;
    mem_ack_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_ce_i == CHIP_ENABLE) begin
          state_d    = ARB_ACCESS;
          owner_d    = OWNER_DATA;
          cnt_d      = CNT_INIT;
          addr_d     = mem_addr_i[ADDR_W+1:2];
          we_d       = mem_we_i;
          sel_d      = mem_sel_i;
          wdata_d    = mem_data_i;
          ce_n_d     = 1'b0;
          oe_n_d     = mem_we_i;
          we_n_d     = ~(mem_we_i && WE_FIRST);
          wdata_oe_d = mem_we_i;
        end else if (if_ce_i == CHIP_ENABLE) begin
          state_d    = ARB_ACCESS;
          owner_d    = OWNER_IF;
          cnt_d      = CNT_INIT;
          addr_d     = if_addr_i[ADDR_W+1:2];
          we_d       = 1'b0;
          sel_d      = 4'b1111;
          wdata_d    = 32'h0;
          ce_n_d     = 1'b0;
          oe_n_d     = 1'b0;
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Final strobe edge: capture read data, strobes drop for DONE
          state_d = ARB_DONE;
          if (!we_q) rdata_d = sram_rdata_i;
          if (owner_q == OWNER_DATA) mem_ack_d = 1'b1;
          else                       if_ack_d  = 1'b1;
        end else begin
          cnt_d      = cnt_q - 4'd1;
          ce_n_d     = 1'b0;
          oe_n_d     = we_q;
          // we_n rises on the last ACCESS cycle to give data hold time
          we_n_d     = ~(we_q && (cnt_q != 4'd1));
          wdata_oe_d = we_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_IF;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= 4'b0000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      wdata_oe_q <= 1'b0;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      wdata_oe_q <= wdata_oe_d;
      if_ack_q   <= if_ack_d;
      mem_ack_q  <= mem_ack_d;
    end
  end

  // A single-cycle strobe cannot pulse we_n, so writes are unsupported there
  a_no_write_single_wait: assert property (@(posedge clk) disable iff (!rst)
    (state_q == ARB_IDLE && mem_ce_i && mem_we_i == WRITE_ENABLE) |-> (WAIT_CYCLES > 1));

  assign sram_addr_o     = addr_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_be_n_o     = ~sel_q;
  assign sram_wdata_o    = wdata_q;
  assign sram_wdata_oe_o = wdata_oe_q;
  assign if_ack_o        = if_ack_q;
  assign mem_ack_o       = mem_ack_q;
  assign if_data_o       = rdata_q;
  assign mem_data_o      = rdata_q;
  assign stallreq_if_o   = if_ce_i & ~if_ack_q;
  assign stallreq_mem_o  = mem_ce_i & ~mem_ack_q;

  // Byte-offset and high address bits are not part of the word address
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter (ADDR_W=20, WAIT_CYCLES=2).
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ack_o, stallreq_if_o;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i, mem_data_o;
  logic        mem_ack_o, stallreq_mem_o;
  logic [19:0] sram_addr_o;
  logic        sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;
  logic [31:0] sram_wdata_o;
  logic        sram_wdata_oe_o;
  logic [31:0] sram_rdata_i;

  int n_chk  = 0;
  int n_fail = 0;

  sram_bus_arbiter #(.ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_ack_o(if_ack_o), .stallreq_if_o(stallreq_if_o),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_ack_o(mem_ack_o), .stallreq_mem_o(stallreq_mem_o),
    .sram_addr_o(sram_addr_o), .sram_ce_n_o(sram_ce_n_o),
    .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o), .sram_wdata_o(sram_wdata_o),
    .sram_wdata_oe_o(sram_wdata_oe_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; if_ce_i = 1'b0; if_addr_i = 32'h0;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0;
    mem_sel_i = 4'h0; mem_data_i = 32'h0; sram_rdata_i = 32'h0;

    // Reset state; stall follows its combinational equation during reset
    nedge(); nedge();
    if_ce_i = 1'b1; #1;
    chk("rst_ce_n",   32'(sram_ce_n_o), 32'h1);
    chk("rst_oe_n",   32'(sram_oe_n_o), 32'h1);
    chk("rst_we_n",   32'(sram_we_n_o), 32'h1);
    chk("rst_be_n",   32'(sram_be_n_o), 32'hF);
    chk("rst_wdoe",   32'(sram_wdata_oe_o), 32'h0);
    chk("rst_acks",   {30'h0, if_ack_o, mem_ack_o}, 32'h0);
    chk("rst_addr",   32'(sram_addr_o), 32'h0);
    chk("rst_data",   if_data_o, 32'h0);
    chk("rst_stall_if", 32'(stallreq_if_o), 32'h1);
    nedge();
    if_ce_i = 1'b0; rst = 1'b1;
    nedge();

    // Fetch read at 0x10 -> word 0x4
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0010; sram_rdata_i = 32'hDEAD_BEEF;
    nedge(); // ACCESS 1
    chk("f_addr",  32'(sram_addr_o), 32'h4);
    chk("f_ce_n1", 32'(sram_ce_n_o), 32'h0);
    chk("f_oe_n1", 32'(sram_oe_n_o), 32'h0);
    chk("f_we_n1", 32'(sram_we_n_o), 32'h1);
    chk("f_be_n",  32'(sram_be_n_o), 32'h0);
    chk("f_stall1", 32'(stallreq_if_o), 32'h1);
    chk("f_ack1",  32'(if_ack_o), 32'h0);
    nedge(); // ACCESS 2
    chk("f_oe_n2", 32'(sram_oe_n_o), 32'h0);
    chk("f_ack2",  32'(if_ack_o), 32'h0);
    nedge(); // DONE
    chk("f_ack",   32'(if_ack_o), 32'h1);
    chk("f_data",  if_data_o, 32'hDEAD_BEEF);
    chk("f_stall_done", 32'(stallreq_if_o), 32'h0);
    chk("f_oe_n_done", 32'(sram_oe_n_o), 32'h1);
    chk("f_ce_n_done", 32'(sram_ce_n_o), 32'h1);
    chk("f_mack",  32'(mem_ack_o), 32'h0);
    if_ce_i = 1'b0;
    nedge(); // IDLE
    chk("f_ack_off", 32'(if_ack_o), 32'h0);

    // Byte store, then an address change mid-access
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0100;
    mem_addr_i = 32'h0000_0021; mem_data_i = 32'h0055_5555;
    nedge(); // ACCESS 1
    chk("s_be_n",  32'(sram_be_n_o), 32'hB);
    chk("s_we_n1", 32'(sram_we_n_o), 32'h0);
    chk("s_wdoe1", 32'(sram_wdata_oe_o), 32'h1);
    chk("s_oe_n1", 32'(sram_oe_n_o), 32'h1);
    chk("s_ce_n1", 32'(sram_ce_n_o), 32'h0);
    chk("s_addr",  32'(sram_addr_o), 32'h8);
    chk("s_wdata", sram_wdata_o, 32'h0055_5555);
    chk("s_stall1", 32'(stallreq_mem_o), 32'h1);
    mem_addr_i = 32'h0000_0FFC; mem_data_i = 32'h1234_5678;
    nedge(); // ACCESS 2
    chk("s_we_n2", 32'(sram_we_n_o), 32'h1);
    chk("s_wdoe2", 32'(sram_wdata_oe_o), 32'h1);
    chk("s_ce_n2", 32'(sram_ce_n_o), 32'h0);
    chk("s_addr_hold",  32'(sram_addr_o), 32'h8);
    chk("s_wdata_hold", sram_wdata_o, 32'h0055_5555);
    nedge(); // DONE
    chk("s_ack",   32'(mem_ack_o), 32'h1);
    chk("s_wdoe_done", 32'(sram_wdata_oe_o), 32'h0);
    chk("s_stall_done", 32'(stallreq_mem_o), 32'h0);
    chk("s_iack",  32'(if_ack_o), 32'h0);
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    nedge();

    // Simultaneous requests: data first, fetch ack at request+7
    mem_ce_i = 1'b1; mem_addr_i = 32'h0000_0040; mem_sel_i = 4'hF;
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0080; sram_rdata_i = 32'h1111_2222;
    nedge(); // 1: data ACCESS 1
    chk("c_addr_d", 32'(sram_addr_o), 32'h10);
    chk("c_stall_if1", 32'(stallreq_if_o), 32'h1);
    chk("c_stall_m1",  32'(stallreq_mem_o), 32'h1);
    nedge(); // 2
    nedge(); // 3: data DONE
    chk("c_mack", 32'(mem_ack_o), 32'h1);
    chk("c_mdata", mem_data_o, 32'h1111_2222);
    chk("c_iack3", 32'(if_ack_o), 32'h0);
    chk("c_stall_if3", 32'(stallreq_if_o), 32'h1);
    mem_ce_i = 1'b0; sram_rdata_i = 32'h3333_4444;
    nedge(); // 4: IDLE turnaround
    chk("c_ce_n4", 32'(sram_ce_n_o), 32'h1);
    nedge(); // 5: fetch ACCESS 1
    chk("c_addr_f", 32'(sram_addr_o), 32'h20);
    chk("c_oe_n5", 32'(sram_oe_n_o), 32'h0);
    nedge(); // 6
    chk("c_iack6", 32'(if_ack_o), 32'h0);
    nedge(); // 7: fetch DONE
    chk("c_iack7", 32'(if_ack_o), 32'h1);
    chk("c_idata", if_data_o, 32'h3333_4444);
    if_ce_i = 1'b0;
    nedge();

    // Fetch dropped mid-access still completes
    if_ce_i = 1'b1; if_addr_i = 32'h0000_0100; sram_rdata_i = 32'hCAFE_F00D;
    nedge(); // ACCESS 1
    if_ce_i = 1'b0; #1;
    chk("d_stall1", 32'(stallreq_if_o), 32'h0);
    nedge(); // ACCESS 2
    chk("d_ce_n2", 32'(sram_ce_n_o), 32'h0);
    nedge(); // DONE
    chk("d_ack",   32'(if_ack_o), 32'h1);
    chk("d_data",  if_data_o, 32'hCAFE_F00D);
    chk("d_stall_done", 32'(stallreq_if_o), 32'h0);
    nedge();

    // Reset in the middle of an access, then a fresh request
    mem_ce_i = 1'b1; mem_addr_i = 32'h0000_0200; sram_rdata_i = 32'h0BAD_0BAD;
    nedge(); // ACCESS 1
    chk("r_ce_n_pre", 32'(sram_ce_n_o), 32'h0);
    #2 rst = 1'b0; #1;
    chk("r_ce_n_async", 32'(sram_ce_n_o), 32'h1);
    chk("r_oe_n_async", 32'(sram_oe_n_o), 32'h1);
    nedge(); nedge();
    chk("r_mack_none", 32'(mem_ack_o), 32'h0);
    chk("r_ce_n_hold", 32'(sram_ce_n_o), 32'h1);
    rst = 1'b1; mem_addr_i = 32'h0000_0300; sram_rdata_i = 32'h5A5A_5A5A;
    nedge(); // ACCESS 1
    chk("r_addr", 32'(sram_addr_o), 32'hC0);
    chk("r_oe_n1", 32'(sram_oe_n_o), 32'h0);
    nedge(); // ACCESS 2
    chk("r_mack2", 32'(mem_ack_o), 32'h0);
    nedge(); // DONE
    chk("r_mack", 32'(mem_ack_o), 32'h1);
    chk("r_mdata", mem_data_o, 32'h5A5A_5A5A);
    mem_ce_i = 1'b0;
    nedge(); nedge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single off-chip SRAM port between the instruction-fetch port and the data port of the memory-access stage. Grants one access at a time, with data given priority over fetch. Drives the multi-cycle SRAM strobe sequence and returns a one-cycle acknowledge. Raises pipeline stall requests toward the ctrl block until each requester's access completes.

## Interface

Parameters:
- ADDR_W, 20, SRAM word-address width; the physical word address is byte addr[ADDR_W+1:2].
- WAIT_CYCLES, 2, SRAM strobe cycles per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch byte address
- if_data_o  out  32  fetch read data, valid while if_ack_o=1
- if_ack_o  out  1  fetch access complete, one-cycle pulse
- stallreq_if_o  out  1  fetch stall request
- mem_ce_i  in  1  data request
- mem_we_i  in  1  data write, already gated by exception in the memory stage
- mem_addr_i  in  32  data byte address
- mem_sel_i  in  4  byte selects; bit 3 = bits [31:24]
- mem_data_i  in  32  store data
- mem_data_o  out  32  load data, valid while mem_ack_o=1
- mem_ack_o  out  1  data access complete, one-cycle pulse
- stallreq_mem_o  out  1  data stall request
- sram_addr_o  out  ADDR_W  word address
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  SRAM strobes, active-low
- sram_be_n_o  out  4  byte enables, active-low; sram_be_n_o = ~sel_q
- sram_wdata_o  out  32  write data
- sram_wdata_oe_o  out  1  tristate enable for write data (pad lives outside)
- sram_rdata_i  in  32  read data from pad

## Operation

FSM states are IDLE, ACCESS and DONE.

- **IDLE:**
  - If mem_ce_i=1, grant data (owner_q=DATA).
  - Else if if_ce_i=1, grant fetch (owner_q=IF).
  - Else stay in IDLE.
  - On grant, latch addr/we/sel/wdata from the winner into *_q registers, load cnt_q=WAIT_CYCLES-1, and go to ACCESS.
  - Fetch grants force we_q=0 and sel_q=4'b1111.
- **ACCESS:**
  - sram_ce_n_o=0.
  - For reads, sram_oe_n_o=0.
  - For writes, sram_wdata_oe_o=1, and sram_we_n_o=0 while cnt_q≠0. we_n rises on the final cycle (cnt_q=0) for data hold.
  - cnt_q decrements each cycle.
  - At cnt_q=0: capture sram_rdata_i into rdata_q (reads only) and go to DONE.
- **DONE:**
  - All strobes are inactive.
  - Pulse the owner's ack; if_data_o/mem_data_o = rdata_q.
  - Next state is always IDLE. There is no back-to-back grant, giving a one-cycle turnaround.
- **Stall requests:**
  - stallreq_mem_o = mem_ce_i & ~mem_ack_o.
  - stallreq_if_o = if_ce_i & ~if_ack_o.
  - Both are combinational.
- **Inputs during an access:**
  - Requesters hold ce/addr until ack. Changes after grant are ignored because the latched copies drive the SRAM.
  - If a requester drops ce mid-access (flush), the access still completes and ack still pulses. The requester discards it; writes are never aborted.
- **Priority:** data always wins in IDLE. Fetch cannot starve because the data stage stalls only while its own request is pending.

## Timing

- **Reset values:**
  - All strobes, sram_be_n_o = 1.
  - sram_wdata_oe_o = 0.
  - Acks = 0.
  - Addr/data outputs and rdata_q = 0.
  - State = IDLE.
  - Stall outputs follow their combinational equations.
- **Reset during ACCESS:** aborts immediately. Strobes deassert asynchronously and no ack is issued.
- **Latency:** request sampled in IDLE at edge N → ACCESS cycles N+1..N+WAIT_CYCLES → ack high in cycle N+WAIT_CYCLES+1. The next grant is possible at edge N+WAIT_CYCLES+2.
- **Read data:** sampled at the last ACCESS edge; mem_data_o/if_data_o stable for the full ack cycle.
- **Simultaneous requests in IDLE:** data is served first. Fetch is granted at the edge after data's DONE, provided if_ce_i is still high.
- **WAIT_CYCLES=1:** writes never assert we_n. This setting is legal for read-only use only; assert on it in simulation if a write occurs.

## Structure

- defines.v gains:
  - `ArbIdle`, `ArbAccess`, `ArbDone` (2-bit state codes)
  - `OwnerIf`, `OwnerData`
  - `SramWaitDefault`
- Existing `ChipEnable`/`WriteEnable` reuse.
- Single module, no sub-module; FSM, counter and latches are together roughly 200 lines.

## Test plan

- Fetch read, WAIT_CYCLES=2, if_addr_i=0x0000_0010, sram_rdata_i=0xDEAD_BEEF → sram_addr_o=0x4, oe_n low 2 cycles, if_ack_o pulse at request+3, if_data_o=0xDEAD_BEEF, stallreq_if_o low in that cycle.
- Byte store: mem_we_i=1, sel=4'b0100, addr=0x0000_0021, data=0x0055_5555 → sram_be_n_o=4'b1011, we_n low only in the first ACCESS cycle, sram_wdata_oe_o high 2 cycles, mem_ack_o pulse.
- Simultaneous if_ce_i and mem_ce_i → data access completes first, fetch grant follows one cycle after mem_ack_o, total if_ack_o at request+7.
- Address changes on mem_addr_i mid-ACCESS → sram_addr_o unchanged, captured value used.
- if_ce_i dropped mid-ACCESS → access completes, if_ack_o still pulses, stallreq_if_o stays 0.
- rst asserted mid-ACCESS → strobes high and state IDLE immediately. After release, a fresh request is served with normal latency.
